// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants for the CNN layer scheduler.
// Stage table, engine op codes, bank selects and FSM encoding.
package cnn_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LAUNCH = 3'd1;
  localparam state_t ST_RUN    = 3'd2;
  localparam state_t ST_NEXT   = 3'd3;
  localparam state_t ST_FIN    = 3'd4;

  localparam logic [1:0] OP_CONV = 2'd0;
  localparam logic [1:0] OP_POOL = 2'd1;
  localparam logic [1:0] OP_FLAT = 2'd2;

  localparam logic [2:0] CS_NONE = 3'd0;
  localparam logic [2:0] CS_C1   = 3'd1;
  localparam logic [2:0] CS_C2   = 3'd2;
  localparam logic [2:0] CS_P1   = 3'd3;
  localparam logic [2:0] CS_P2   = 3'd4;
  localparam logic [2:0] CS_FL   = 3'd5;

  localparam logic [2:0] STG_S0   = 3'd0;
  localparam logic [2:0] STG_S1   = 3'd1;
  localparam logic [2:0] STG_S2   = 3'd2;
  localparam logic [2:0] STG_S3   = 3'd3;
  localparam logic [2:0] STG_S4   = 3'd4;
  localparam logic [2:0] STG_LAST = STG_S4;

  function automatic logic [1:0] stage_op(
    input logic [2:0] stg
  );
    logic [1:0] op;
    op = OP_CONV;
    case (stg)
      STG_S2, STG_S3: op = OP_POOL;
      STG_S4:         op = OP_FLAT;
      default:        op = OP_CONV;
    endcase
    return op;
  endfunction

  function automatic logic stage_ksel(
    input logic [2:0] stg
  );
    return (stg == STG_S1) || (stg == STG_S3);
  endfunction

  function automatic logic [2:0] stage_wcs(
    input logic [2:0] stg
  );
    logic [2:0] cs;
    cs = CS_NONE;
    case (stg)
      STG_S0:  cs = CS_C1;
      STG_S1:  cs = CS_C2;
      STG_S2:  cs = CS_P1;
      STG_S3:  cs = CS_P2;
      STG_S4:  cs = CS_FL;
      default: cs = CS_NONE;
    endcase
    return cs;
  endfunction

  // Convolution stages have no source bank; flatten picks its pool bank.
  function automatic logic [2:0] stage_rcs(
    input logic [2:0] stg,
    input logic       rd_bank
  );
    logic [2:0] cs;
    cs = CS_NONE;
    case (stg)
      STG_S2:  cs = CS_C1;
      STG_S3:  cs = CS_C2;
      STG_S4:  cs = rd_bank ? CS_P2 : CS_P1;
      default: cs = CS_NONE;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: counts RUN cycles of one stage.
// expired is high on the cycle whose edge makes the count reach LIMIT.
module stage_watchdog #(
  parameter logic [19:0] LIMIT = 20'd300000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [19:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 20'd1;
    end
  end

  assign expired = en && (cnt == LIMIT - 20'd1);

endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences the five CNN stages on the engine
// and steers engine memory strobes onto the layer-memory banks.
module layer_scheduler
  import cnn_pkg::*;
#(
  parameter logic [19:0] WD_CYCLES = 20'd300000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic        err,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic        eng_ksel,
  input  logic        eng_done,
  input  logic        eng_cwr,
  input  logic        eng_crd,
  input  logic [11:0] eng_caddr_wr,
  input  logic [11:0] eng_caddr_rd,
  input  logic [19:0] eng_cdata_wr,
  input  logic        eng_rd_bank,
  output logic        cwr,
  output logic        crd,
  output logic [11:0] caddr_wr,
  output logic [11:0] caddr_rd,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  state_t     state;
  logic [2:0] stage;
  logic [2:0] stage_nxt;
  logic       in_run;
  logic       wd_clr;
  logic       wd_exp;
  logic       conflict;

  assign in_run    = (state == ST_RUN);
  assign wd_clr    = (state == ST_LAUNCH);
  assign conflict  = in_run && eng_cwr && eng_crd;
  assign stage_nxt = stage + 3'd1;

  stage_watchdog #(
    .LIMIT(WD_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (in_run),
    .expired(wd_exp)
  );

  // Write strobe wins a same-cycle clash with read.
  always_comb begin
    cwr  = in_run && eng_cwr;
    crd  = in_run && eng_crd && !eng_cwr;
    csel = CS_NONE;
    if (cwr) begin
      csel = stage_wcs(stage);
    end else if (crd) begin
      csel = stage_rcs(stage, eng_rd_bank);
    end
  end

  assign caddr_wr = eng_caddr_wr;
  assign caddr_rd = eng_caddr_rd;
  assign cdata_wr = eng_cdata_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      stage     <= STG_S0;
      busy      <= 1'b0;
      err       <= 1'b0;
      eng_start <= 1'b0;
      eng_op    <= OP_CONV;
      eng_ksel  <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (conflict) begin
        err <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (ready) begin
            state     <= ST_LAUNCH;
            stage     <= STG_S0;
            busy      <= 1'b1;
            err       <= 1'b0;
            eng_start <= 1'b1;
            eng_op    <= stage_op(STG_S0);
            eng_ksel  <= stage_ksel(STG_S0);
          end
        end
        ST_LAUNCH: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (wd_exp) begin
            err   <= 1'b1;
            state <= ST_FIN;
          end else if (eng_done) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (stage != STG_LAST) begin
            state     <= ST_LAUNCH;
            stage     <= stage_nxt;
            eng_start <= 1'b1;
            eng_op    <= stage_op(stage_nxt);
            eng_ksel  <= stage_ksel(stage_nxt);
          end else begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: random engine timing and port traffic
// checked against a table-driven model of the stage sequence.
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_cwr = 1'b0;
  logic        eng_crd = 1'b0;
  logic        eng_rd_bank = 1'b0;
  logic [11:0] eng_caddr_wr = '0;
  logic [11:0] eng_caddr_rd = '0;
  logic [19:0] eng_cdata_wr = '0;
  logic        busy, err, eng_start, eng_ksel, cwr, crd;
  logic [1:0]  eng_op;
  logic [11:0] caddr_wr, caddr_rd;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  int checks = 0;
  int errors = 0;
  int nstarts = 0;

  logic [1:0] t_op [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  logic       t_ks [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0] t_wc [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [2:0] t_rc [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};

  layer_scheduler #(
    .WD_CYCLES(20'd50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .busy        (busy),
    .err         (err),
    .eng_start   (eng_start),
    .eng_op      (eng_op),
    .eng_ksel    (eng_ksel),
    .eng_done    (eng_done),
    .eng_cwr     (eng_cwr),
    .eng_crd     (eng_crd),
    .eng_caddr_wr(eng_caddr_wr),
    .eng_caddr_rd(eng_caddr_rd),
    .eng_cdata_wr(eng_cdata_wr),
    .eng_rd_bank (eng_rd_bank),
    .cwr         (cwr),
    .crd         (crd),
    .caddr_wr    (caddr_wr),
    .caddr_rd    (caddr_rd),
    .cdata_wr    (cdata_wr),
    .csel        (csel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_start) nstarts++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic port_set(input int k, input bit run, input bit w,
                          input bit r, input bit bank,
                          input logic [11:0] aw);
    logic [2:0] ecs;
    eng_cwr      = w;
    eng_crd      = r;
    eng_rd_bank  = bank;
    eng_caddr_wr = aw;
    eng_caddr_rd = 12'($urandom);
    eng_cdata_wr = 20'($urandom);
    #1;
    ecs = 3'd0;
    if (run && w) ecs = t_wc[k];
    else if (run && r) ecs = (k == 4) ? (bank ? 3'd4 : 3'd3) : t_rc[k];
    check("cwr", {31'd0, cwr}, {31'd0, run && w});
    check("crd", {31'd0, crd}, {31'd0, run && r && !w});
    check("csel", {29'd0, csel}, {29'd0, ecs});
    check("caddr_wr", {20'd0, caddr_wr}, {20'd0, eng_caddr_wr});
    check("caddr_rd", {20'd0, caddr_rd}, {20'd0, eng_caddr_rd});
    check("cdata_wr", {12'd0, cdata_wr}, {12'd0, eng_cdata_wr});
  endtask

  task automatic port_rand(input int k);
    bit w, r;
    w = 1'($urandom);
    r = w ? 1'b0 : 1'($urandom);
    port_set(k, 1'b1, w, r, 1'($urandom), 12'($urandom));
  endtask

  task automatic go();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("start_lat", {31'd0, eng_start}, 32'd1);
    check("busy_on", {31'd0, busy}, 32'd1);
    check("err_clr", {31'd0, err}, 32'd0);
  endtask

  // Entered at the negedge of the stage's start cycle.
  task automatic stage(input int k, input int dly, input bit noise,
                       input bit clash);
    check("op", {30'd0, eng_op}, {30'd0, t_op[k]});
    check("ksel", {31'd0, eng_ksel}, {31'd0, t_ks[k]});
    port_set(k, 1'b0, 1'b1, 1'b1, 1'b0, 12'($urandom));
    @(negedge clk);
    check("start_1cyc", {31'd0, eng_start}, 32'd0);
    if (clash) begin
      port_set(k, 1'b1, 1'b1, 1'b1, 1'b0, 12'($urandom));
      @(negedge clk);
      check("err_conf", {31'd0, err}, 32'd1);
    end
    if (k == 2) begin
      port_set(2, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0A5);
      @(negedge clk);
      port_set(2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0A5);
      @(negedge clk);
    end
    if (k == 4) begin
      port_set(4, 1'b1, 1'b0, 1'b1, 1'b1, 12'($urandom));
      @(negedge clk);
    end
    for (int i = 0; i < dly; i++) begin
      ready = noise ? 1'($urandom) : 1'b0;
      port_rand(k);
      @(negedge clk);
    end
    ready    = 1'b0;
    eng_cwr  = 1'b0;
    eng_crd  = 1'b0;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    check("start_gap", {31'd0, eng_start}, 32'd0);
    if (k < 4) begin
      @(negedge clk);
      check("start_m2", {31'd0, eng_start}, 32'd1);
    end
  endtask

  initial begin
    int s0;
    int n;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_start", {31'd0, eng_start}, 32'd0);
    check("rst_op", {30'd0, eng_op}, 32'd0);
    check("rst_ksel", {31'd0, eng_ksel}, 32'd0);
    check("rst_csel", {29'd0, csel}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    s0 = nstarts;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done", nstarts - s0, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 3; r++) begin
      s0 = nstarts;
      go();
      for (int k = 0; k < 5; k++)
        stage(k, int'($urandom_range(2, 12)), r == 1, 1'b0);
      @(negedge clk);
      check("fin_busy", {31'd0, busy}, 32'd1);
      check("nom_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      check("busy_off", {31'd0, busy}, 32'd0);
      check("nstarts", nstarts - s0, 32'd5);
    end

    go();
    for (int k = 0; k < 5; k++)
      stage(k, int'($urandom_range(2, 12)), 1'b0, k == 0);
    @(negedge clk);
    check("conf_fin", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("conf_idle", {31'd0, err}, 32'd1);

    s0 = nstarts;
    go();
    stage(0, int'($urandom_range(2, 12)), 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 100);
    check("wd_lat", n, 32'd51);
    check("wd_fin", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wd_idle", {31'd0, busy}, 32'd0);
    check("wd_err", {31'd0, err}, 32'd1);
    check("wd_starts", nstarts - s0, 32'd2);

    go();
    for (int k = 0; k < 3; k++)
      stage(k, int'($urandom_range(2, 12)), 1'b0, 1'b0);
    @(negedge clk);
    eng_cwr = 1'b1;
    #1;
    check("s3_cwr", {31'd0, cwr}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_cwr", {31'd0, cwr}, 32'd0);
    check("ar_crd", {31'd0, crd}, 32'd0);
    check("ar_csel", {29'd0, csel}, 32'd0);
    s0 = nstarts;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    eng_cwr = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_starts", nstarts - s0, 32'd0);
    go();
    for (int k = 0; k < 5; k++)
      stage(k, int'($urandom_range(2, 12)), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("ar_done", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter WD_CYCLES, default 20'd300000, sets the per-stage watchdog limit in clk cycles.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ready  in  1  testbench start request, sampled only in IDLE.
REQ-005 busy  out  1  high from the first LAUNCH through FIN.
REQ-006 err  out  1  sticky fault flag: watchdog expiry or port conflict.
REQ-007 eng_start  out  1  one-cycle start pulse to the datapath engine.
REQ-008 eng_op  out  2  operation for the engine: 0 conv, 1 maxpool, 2 flatten.
REQ-009 eng_ksel  out  1  kernel/bank index for the current stage.
REQ-010 eng_done  in  1  engine completion pulse, sampled only in RUN.
REQ-011 eng_cwr, eng_crd  in  1 each  engine write/read strobes.
REQ-012 eng_caddr_wr, eng_caddr_rd  in  12 each  engine addresses.
REQ-013 eng_cdata_wr  in  20  engine write data.
REQ-014 eng_rd_bank  in  1  flatten source bank: 0 selects csel 3, 1 selects csel 4.
REQ-015 cwr, crd  out  1 each  layer-memory strobes.
REQ-016 caddr_wr, caddr_rd  out  12 each; cdata_wr  out  20  layer-memory address/data.
REQ-017 csel  out  3  layer-memory bank select.

Function
REQ-018 The stage table SHALL be, as (op, ksel, write csel, read csel):
- S0 = (conv, 0, 1, none)
- S1 = (conv, 1, 2, none)
- S2 = (pool, 0, 3, 1)
- S3 = (pool, 1, 4, 2)
- S4 = (flatten, 0, 5, 3 or 4 per eng_rd_bank)
REQ-019 FSM states SHALL be IDLE, LAUNCH, RUN, NEXT, FIN.
REQ-020 Transitions SHALL be:
- IDLE->LAUNCH when ready=1
- LAUNCH->RUN unconditionally
- RUN->NEXT on eng_done
- NEXT->LAUNCH if stage<4, else NEXT->FIN
- FIN->IDLE unconditionally
REQ-021 Outputs SHALL be registered: ready sampled at edge N gives busy=1 and eng_start=1 during cycle N+1, with eng_op/eng_ksel valid from N+1.
REQ-022 eng_start SHALL be high exactly one cycle per stage; five pulses SHALL occur per run.
REQ-023 eng_done sampled in RUN at edge M SHALL give the next stage's eng_start at cycle M+2; eng_done outside RUN SHALL be ignored.
REQ-024 ready asserted while busy=1 SHALL be ignored; no restart until IDLE.
REQ-025 Memory port signals SHALL be combinational pass-through, gated to cwr=crd=0 outside RUN.
REQ-026 csel SHALL equal the stage write csel when eng_cwr=1, else the read csel; it SHALL be 0 when neither strobe is set.
REQ-027 When eng_cwr=eng_crd=1 in the same cycle, write SHALL win, crd SHALL be forced to 0, and err SHALL set.
REQ-028 A watchdog counter SHALL clear on LAUNCH and increment in RUN; reaching WD_CYCLES SHALL set err and force the FSM to FIN.
REQ-029 busy SHALL fall to 0 in the cycle after FIN; err SHALL clear only on reset or the next IDLE->LAUNCH.

Reset
REQ-030 reset=0 SHALL immediately set IDLE, stage=0, watchdog=0, busy=0, err=0, eng_start=0, eng_op=0, eng_ksel=0.
REQ-031 reset=0 SHALL immediately force cwr=0, crd=0, csel=0.
REQ-032 Reset asserted mid-run SHALL abort the run with no further eng_start; release SHALL resume from IDLE awaiting ready.

Structure
REQ-033 Stage encodings, eng_op codes, csel bank constants and the FSM state enum SHALL live in a shared cnn_pkg package.
REQ-034 The watchdog SHALL be a sub-module named stage_watchdog with ports clr, en, expired.

Verification
REQ-035 Nominal run: ready=1 at edge 0, engine model pulses done 10 cycles after each start -> five eng_start pulses with op/ksel sequence (0,0) (0,1) (1,0) (1,1) (2,0); busy falls after the 5th done; err=0.
REQ-036 Bank steering: in S2, eng_cwr=1 with eng_caddr_wr=12'h0A5 -> csel=3, caddr_wr=12'h0A5; eng_crd=1 -> csel=1; in S4 with eng_rd_bank=1 and crd -> csel=4.
REQ-037 Conflict: eng_cwr=eng_crd=1 in S0 -> cwr=1, crd=0, err=1 and held through FIN.
REQ-038 Watchdog: WD_CYCLES=20'd50 and no done in S1 -> err=1 at RUN cycle 50, FSM reaches FIN, busy=0, only two starts seen.
REQ-039 Spurious inputs: eng_done pulsed in IDLE and ready pulsed in RUN -> no state change, no extra eng_start.
REQ-040 Reset mid-S3: reset=0 for 2 cycles -> busy=0, cwr=crd=csel=0 asynchronously; a new ready restarts at S0.
